rnd_backoff: RTL and testbench

Randomised exponential-backoff timer for a retry path, such as a NoC/crossbar port retransmitting after a NACK or a lost arbitration. It sits directly downstream of the 3-bit pseudo-random generator.
- Consumes the generator's 3-bit value.
- Pulses the generator's shift input once per draw.
- Counts out a delay of (rnd+1) << min(attempts, MAX_EXP) cycles, then signals expiry.
- Tracks consecutive failed attempts and reports give-up at a configured limit.

---
 rtl/rnd_backoff_pkg.sv | 26 ++
 rtl/rnd_backoff.sv | 139 +++++++++++++
 tb/tb_rnd_backoff.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rnd_backoff_pkg.sv
// -----------------------------------------------------------------------------
// rnd_backoff_pkg
// Shared definitions for randomised retry/backoff blocks.
//   backoff_state_e    : IDLE / WAIT / DONE state encoding
//   BACKOFF_RND_W      : width of the random draw from the shared generator
//   BACKOFF_BASE_W     : width of (rnd + 1) before shifting
//   backoff_min_cnt_w  : smallest delay-counter width that cannot wrap for a
//                        given exponent cap
// -----------------------------------------------------------------------------
package rnd_backoff_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } backoff_state_e;

    localparam int unsigned BACKOFF_RND_W  = 3;
    localparam int unsigned BACKOFF_BASE_W = BACKOFF_RND_W + 1;

    // (rnd + 1) needs BACKOFF_BASE_W bits, then it is shifted by up to max_exp.
    function automatic int unsigned backoff_min_cnt_w(input int unsigned max_exp);
        return BACKOFF_BASE_W + max_exp;
    endfunction

endpackage

// File: rtl/rnd_backoff.sv
// -----------------------------------------------------------------------------
// rnd_backoff
// Randomised exponential-backoff timer for a retry path. Draws a 3-bit value
// from an external shared generator, waits (rnd+1) << min(attempts, MAX_EXP)
// cycles, then pulses o_expired. Consecutive failed attempts are counted and a
// start at the limit is refused with o_giveup.
//
// Ports:
//   Clk          clock
//   Reset        asynchronous, active-high reset
//   i_start      request a backoff (previous attempt failed)
//   i_success    attempt succeeded; clears attempt history, cancels a wait
//   i_abort      cancel a running backoff
//   i_rnd        random value from the generator
//   o_rnd_shift  one-cycle pulse advancing the generator after a draw
//   o_busy       backoff running (WAIT or DONE)
//   o_expired    one-cycle pulse when the delay has elapsed
//   o_giveup     one-cycle pulse when a start is refused at the limit
//   o_attempts   current failed-attempt count
//   o_delay      delay latched at the last accepted start
// -----------------------------------------------------------------------------
module rnd_backoff
    import rnd_backoff_pkg::*;
#(
    parameter int unsigned CNT_W        = 12,
    parameter int unsigned MAX_EXP      = 6,
    parameter int unsigned MAX_ATTEMPTS = 8
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     i_start,
    input  logic                     i_success,
    input  logic                     i_abort,
    input  logic [BACKOFF_RND_W-1:0] i_rnd,
    output logic                     o_rnd_shift,
    output logic                     o_busy,
    output logic                     o_expired,
    output logic                     o_giveup,
    output logic [3:0]               o_attempts,
    output logic [CNT_W-1:0]         o_delay
);

    localparam logic [3:0]       MAX_EXP_L = 4'(MAX_EXP);
    localparam logic [3:0]       MAX_ATT_L = 4'(MAX_ATTEMPTS);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    backoff_state_e            r_state;
    logic [CNT_W-1:0]          r_cnt;
    logic [CNT_W-1:0]          r_delay;
    logic [3:0]                r_attempts;
    logic                      r_rnd_shift;
    logic                      r_expired;
    logic                      r_giveup;

    logic [3:0]                w_exp;
    logic [BACKOFF_BASE_W-1:0] w_base;
    logic [CNT_W-1:0]          w_delay;
    logic                      w_req;
    logic                      w_accept;
    logic                      w_refuse;
    logic                      w_cancel;
    logic                      w_cnt_zero;
    logic [3:0]                w_att_inc;

    // Exponent is capped so the shifted delay always fits in CNT_W.
    assign w_exp   = (r_attempts > MAX_EXP_L) ? MAX_EXP_L : r_attempts;
    assign w_base  = {1'b0, i_rnd} + 4'd1;
    assign w_delay = CNT_W'(w_base) << w_exp;

    // Success in the same cycle suppresses a start entirely.
    assign w_req    = (r_state == IDLE) && i_start && !i_success;
    assign w_accept = w_req && (r_attempts < MAX_ATT_L);
    assign w_refuse = w_req && (r_attempts >= MAX_ATT_L);

    // Success or abort beats the terminal count, so no expiry slips out.
    assign w_cancel   = (r_state == WAIT) && (i_abort || i_success);
    assign w_cnt_zero = (r_cnt == '0);
    assign w_att_inc  = (r_attempts >= MAX_ATT_L) ? MAX_ATT_L : (r_attempts + 4'd1);

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_delay     <= '0;
            r_attempts  <= '0;
            r_rnd_shift <= 1'b0;
            r_expired   <= 1'b0;
            r_giveup    <= 1'b0;
        end else begin
            r_rnd_shift <= 1'b0;
            r_expired   <= 1'b0;
            r_giveup    <= 1'b0;

            if (i_success) begin
                r_attempts <= '0;
            end

            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_cnt       <= w_delay - CNT_ONE;
                        r_delay     <= w_delay;
                        r_rnd_shift <= 1'b1;
                        r_state     <= WAIT;
                    end else if (w_refuse) begin
                        r_giveup <= 1'b1;
                    end
                end
                WAIT: begin
                    if (w_cancel) begin
                        r_cnt   <= '0;
                        r_state <= IDLE;
                    end else if (w_cnt_zero) begin
                        r_expired  <= 1'b1;
                        r_attempts <= w_att_inc;
                        r_state    <= DONE;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign o_busy      = (r_state != IDLE);
    assign o_rnd_shift = r_rnd_shift;
    assign o_expired   = r_expired;
    assign o_giveup    = r_giveup;
    assign o_attempts  = r_attempts;
    assign o_delay     = r_delay;

endmodule

// File: tb/tb_rnd_backoff.sv
// -----------------------------------------------------------------------------
// tb_rnd_backoff
// Directed bench for rnd_backoff with hand-computed delays and attempt counts.
// -----------------------------------------------------------------------------
module tb_rnd_backoff;

    localparam int unsigned CNT_W = 12;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             i_start;
    logic             i_success;
    logic             i_abort;
    logic [2:0]       i_rnd;
    logic             o_rnd_shift;
    logic             o_busy;
    logic             o_expired;
    logic             o_giveup;
    logic [3:0]       o_attempts;
    logic [CNT_W-1:0] o_delay;

    int n_checks = 0;
    int n_fail   = 0;

    rnd_backoff #(
        .CNT_W        (CNT_W),
        .MAX_EXP      (6),
        .MAX_ATTEMPTS (8)
    ) u_dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .i_start     (i_start),
        .i_success   (i_success),
        .i_abort     (i_abort),
        .i_rnd       (i_rnd),
        .o_rnd_shift (o_rnd_shift),
        .o_busy      (o_busy),
        .o_expired   (o_expired),
        .o_giveup    (o_giveup),
        .o_attempts  (o_attempts),
        .o_delay     (o_delay)
    );

    always #5 Clk = ~Clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Count o_expired pulses over n cycles; none are allowed.
    task automatic watch_quiet(input string tag, input int n);
        int hits;
        hits = 0;
        for (int i = 0; i < n; i++) begin
            step();
            if (o_expired) hits++;
        end
        check_eq(tag, hits, 0);
    endtask

    // Full start -> expire sequence with hand-computed delay and resulting count.
    task automatic run_backoff(input string tag, input logic [2:0] rnd, input int exp_d,
                               input int exp_att);
        int k;
        int busy_cnt;
        int shifts;
        i_rnd   = rnd;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        i_rnd   = ~rnd;
        check_eq({tag, " shift"}, o_rnd_shift, 1);
        check_eq({tag, " busy"}, o_busy, 1);
        check_eq({tag, " delay"}, o_delay, exp_d);
        k        = 0;
        busy_cnt = 1;
        shifts   = 1;
        while (!o_expired && k < 300) begin
            step();
            k++;
            if (o_busy) busy_cnt++;
            if (o_rnd_shift) shifts++;
        end
        check_eq({tag, " expire latency"}, k, exp_d);
        check_eq({tag, " busy cycles"}, busy_cnt, exp_d + 1);
        check_eq({tag, " shift pulses"}, shifts, 1);
        check_eq({tag, " delay held"}, o_delay, exp_d);
        step();
        check_eq({tag, " busy after"}, o_busy, 0);
        check_eq({tag, " expired after"}, o_expired, 0);
        check_eq({tag, " attempts"}, o_attempts, exp_att);
    endtask

    initial begin
        Reset     = 1'b1;
        i_start   = 1'b0;
        i_success = 1'b0;
        i_abort   = 1'b0;
        i_rnd     = 3'd7;
        step();
        step();
        check_eq("reset busy", o_busy, 0);
        check_eq("reset expired", o_expired, 0);
        check_eq("reset shift", o_rnd_shift, 0);
        check_eq("reset giveup", o_giveup, 0);
        check_eq("reset attempts", o_attempts, 0);
        check_eq("reset delay", o_delay, 0);
        Reset = 1'b0;
        step();

        // Exponent grows 0..6 then caps; attempts saturate at 8.
        run_backoff("r7a0", 3'd7, 8, 1);
        run_backoff("r0a1", 3'd0, 2, 2);
        run_backoff("r0a2", 3'd0, 4, 3);
        run_backoff("r2a3", 3'd2, 24, 4);
        run_backoff("r0a4", 3'd0, 16, 5);
        run_backoff("r0a5", 3'd0, 32, 6);
        run_backoff("r0a6", 3'd0, 64, 7);
        run_backoff("r0a7 capped", 3'd0, 64, 8);

        // Start at the limit is refused.
        i_rnd   = 3'd4;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check_eq("giveup pulse", o_giveup, 1);
        check_eq("giveup shift", o_rnd_shift, 0);
        check_eq("giveup busy", o_busy, 0);
        check_eq("giveup attempts", o_attempts, 8);
        step();
        check_eq("giveup one cycle", o_giveup, 0);
        check_eq("giveup still idle", o_busy, 0);

        // Success beats a simultaneous start.
        i_start   = 1'b1;
        i_success = 1'b1;
        step();
        i_start   = 1'b0;
        i_success = 1'b0;
        check_eq("succ+start shift", o_rnd_shift, 0);
        check_eq("succ+start busy", o_busy, 0);
        check_eq("succ+start giveup", o_giveup, 0);
        check_eq("succ+start attempts", o_attempts, 0);
        check_eq("succ+start delay kept", o_delay, 64);

        run_backoff("after success e0", 3'd7, 8, 1);

        // Abort with counter at 5: D=12, counter=11-k after k edges.
        i_rnd   = 3'd5;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check_eq("abort delay", o_delay, 12);
        repeat (6) step();
        check_eq("abort pre busy", o_busy, 1);
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check_eq("abort busy", o_busy, 0);
        check_eq("abort expired", o_expired, 0);
        check_eq("abort attempts", o_attempts, 1);
        watch_quiet("abort quiet", 20);

        // Success mid-wait: D=2 at attempts 1.
        i_rnd   = 3'd0;
        i_start = 1'b1;
        step();
        i_start   = 1'b0;
        i_success = 1'b1;
        step();
        i_success = 1'b0;
        check_eq("succ wait busy", o_busy, 0);
        check_eq("succ wait attempts", o_attempts, 0);
        watch_quiet("succ wait quiet", 10);

        // Success on the terminal edge: D=4, counter 0 after 3 edges.
        i_rnd   = 3'd3;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        repeat (3) step();
        check_eq("succ zero pre busy", o_busy, 1);
        check_eq("succ zero pre expired", o_expired, 0);
        i_success = 1'b1;
        step();
        i_success = 1'b0;
        check_eq("succ zero busy", o_busy, 0);
        check_eq("succ zero expired", o_expired, 0);
        check_eq("succ zero attempts", o_attempts, 0);
        watch_quiet("succ zero quiet", 10);

        // D=1 boundary, then abort on the terminal edge.
        run_backoff("d1", 3'd0, 1, 1);
        i_rnd   = 3'd0;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check_eq("abort zero delay", o_delay, 2);
        step();
        i_abort = 1'b1;
        step();
        i_abort = 1'b0;
        check_eq("abort zero busy", o_busy, 0);
        check_eq("abort zero expired", o_expired, 0);
        check_eq("abort zero attempts", o_attempts, 1);
        watch_quiet("abort zero quiet", 10);

        // Asynchronous reset mid-wait: D=16 at attempts 1.
        i_rnd   = 3'd7;
        i_start = 1'b1;
        step();
        i_start = 1'b0;
        check_eq("rst wait delay", o_delay, 16);
        repeat (4) step();
        #2;
        Reset = 1'b1;
        #1;
        check_eq("rst async busy", o_busy, 0);
        check_eq("rst async attempts", o_attempts, 0);
        check_eq("rst async delay", o_delay, 0);
        check_eq("rst async shift", o_rnd_shift, 0);
        step();
        Reset = 1'b0;
        watch_quiet("rst quiet", 30);

        run_backoff("post reset", 3'd1, 2, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
